ahb_loader_master: RTL

AHB_LOADER_MASTER -- requirements
Module: ahb_loader_master

---
 rtl/ahb_loader_master.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/ahb_loader_master.sv
// Command-driven AHB-style loader: word bursts in and out of memory plus CPU run/halt control.
// Optional macro AHB_LOADER_TIMEOUT_EN adds a 256-cycle ahb_ready watchdog.
module ahb_loader_master #(
  parameter logic [31:0] CPU_RSTN_ADDR = 32'h4000_8004,
  parameter int unsigned MAX_LEN       = 2048
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_addr,
  input  logic [11:0] cmd_len,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [31:0] rd_data,
  output logic        ahb_we,
  output logic [31:0] ahb_addr,
  output logic [31:0] ahb_write_data,
  input  logic        ahb_ready,
  input  logic        ahb_resp,
  input  logic [31:0] ahb_read_data,
  output logic        busy,
  output logic        err
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 12;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_RUN   = 2'd2;

  typedef enum logic [2:0] {
    IDLE, WR_WAIT, WR_BEAT, RD_ADDR, RD_DATA, RD_PUSH, CTRL
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [LW-1:0]   cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic            err_q, err_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            busy_q, busy_d;
  logic            wr_ready_q, wr_ready_d;
  logic            rd_valid_q, rd_valid_d;
  logic [DW-1:0]   rd_data_q, rd_data_d;
  logic            ahb_we_q, ahb_we_d;
  logic [AW-1:0]   ahb_addr_q, ahb_addr_d;
  logic [DW-1:0]   ahb_write_data_q, ahb_write_data_d;

`ifdef AHB_LOADER_TIMEOUT_EN
  localparam int unsigned TW = 8;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            beat_st;
`endif

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    cnt_d            = cnt_q;
    op_d             = op_q;
    err_d            = err_q;
    rd_data_d        = rd_data_q;
    ahb_write_data_d = ahb_write_data_q;
    ahb_addr_d       = ahb_addr_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d = cmd_addr & ~AW'(3);
          cnt_d  = cmd_len;
          op_d   = cmd_op;
          err_d  = 1'b0;
          if (cmd_op == OP_WRITE || cmd_op == OP_READ) begin
            if (cmd_len == '0) begin
              state_d = IDLE;
            end else if (32'(cmd_len) > MAX_LEN) begin
              err_d = 1'b1;
            end else begin
              state_d = (cmd_op == OP_WRITE) ? WR_WAIT : RD_ADDR;
            end
          end else begin
            state_d = CTRL;
          end
        end
      end
      WR_WAIT: begin
        if (wr_valid) begin
          ahb_write_data_d = wr_data;
          state_d          = WR_BEAT;
        end
      end
      WR_BEAT: begin
        if (ahb_ready) begin
          if (ahb_resp) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            addr_d  = addr_q + AW'(4);
            cnt_d   = cnt_q - LW'(1);
            state_d = (cnt_q == LW'(1)) ? IDLE : WR_WAIT;
          end
        end
      end
      RD_ADDR: state_d = RD_DATA;
      RD_DATA: begin
        if (ahb_ready) begin
          if (ahb_resp) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            rd_data_d = ahb_read_data;
            state_d   = RD_PUSH;
          end
        end
      end
      RD_PUSH: begin
        if (rd_ready) begin
          addr_d  = addr_q + AW'(4);
          cnt_d   = cnt_q - LW'(1);
          state_d = (cnt_q == LW'(1)) ? IDLE : RD_ADDR;
        end
      end
      CTRL: begin
        if (ahb_ready) begin
          if (ahb_resp) err_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef AHB_LOADER_TIMEOUT_EN
    // Watchdog on consecutive not-ready cycles of a bus beat
    beat_st = (state_q == WR_BEAT) || (state_q == RD_DATA) || (state_q == CTRL);
    tmo_d   = '0;
    if (beat_st && !ahb_ready) begin
      tmo_d = tmo_q + TW'(1);
      if (tmo_q == {TW{1'b1}}) begin
        err_d   = 1'b1;
        state_d = IDLE;
        tmo_d   = '0;
      end
    end
`endif

    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    wr_ready_d  = (state_d == WR_WAIT);
    rd_valid_d  = (state_d == RD_PUSH);
    ahb_we_d    = (state_d == WR_BEAT) || (state_d == CTRL);

    // Bus address/data only move when a new beat is presented; IDLE holds them
    if (state_d == WR_BEAT || state_d == RD_ADDR) begin
      ahb_addr_d = addr_d;
    end else if (state_d == CTRL) begin
      ahb_addr_d       = CPU_RSTN_ADDR;
      ahb_write_data_d = DW'(op_d == OP_RUN);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q          <= IDLE;
      addr_q           <= '0;
      cnt_q            <= '0;
      op_q             <= '0;
      err_q            <= 1'b0;
      cmd_ready_q      <= 1'b0;
      busy_q           <= 1'b0;
      wr_ready_q       <= 1'b0;
      rd_valid_q       <= 1'b0;
      rd_data_q        <= '0;
      ahb_we_q         <= 1'b0;
      ahb_addr_q       <= '0;
      ahb_write_data_q <= '0;
`ifdef AHB_LOADER_TIMEOUT_EN
      tmo_q            <= '0;
`endif
    end else begin
      state_q          <= state_d;
      addr_q           <= addr_d;
      cnt_q            <= cnt_d;
      op_q             <= op_d;
      err_q            <= err_d;
      cmd_ready_q      <= cmd_ready_d;
      busy_q           <= busy_d;
      wr_ready_q       <= wr_ready_d;
      rd_valid_q       <= rd_valid_d;
      rd_data_q        <= rd_data_d;
      ahb_we_q         <= ahb_we_d;
      ahb_addr_q       <= ahb_addr_d;
      ahb_write_data_q <= ahb_write_data_d;
`ifdef AHB_LOADER_TIMEOUT_EN
      tmo_q            <= tmo_d;
`endif
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign busy           = busy_q;
  assign err            = err_q;
  assign wr_ready       = wr_ready_q;
  assign rd_valid       = rd_valid_q;
  assign rd_data        = rd_data_q;
  assign ahb_we         = ahb_we_q;
  assign ahb_addr       = ahb_addr_q;
  assign ahb_write_data = ahb_write_data_q;

endmodule
